// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Bridges a byte-addressed CPU load/store port onto a 16-bit word-wide RAM.
// Byte loads extract and zero-extend one lane. Byte stores use a
// read-modify-write cycle, because the RAM is always written a full word at a
// time (ram_be is tied to 2'b11). A word access with addr[0]=1 is rejected with
// cpu_err and never touches the RAM.
//
// Ports
//   clk        in   clock, all state updates on rising edge
//   rst_n      in   asynchronous active-low reset
//   cpu_req    in   access request, sampled only while idle
//   cpu_we     in   1 = store, 0 = load
//   cpu_byte   in   1 = byte access, 0 = word access
//   cpu_addr   in   byte address, bit 0 selects the lane
//   cpu_wdata  in   store data (byte stores use [7:0])
//   cpu_rdata  out  registered load result, valid while cpu_ack = 1
//   cpu_ack    out  one-cycle completion pulse
//   cpu_err    out  misaligned word access, qualified by cpu_ack
//   busy       out  high whenever the FSM is not idle
//   ram_addr   out  RAM word address
//   ram_wdata  out  RAM write data
//   ram_be     out  RAM byte enables, always 2'b11
//   ram_we     out  RAM write strobe
//   ram_rdata  in   RAM read data, one cycle after ram_addr is sampled
// -----------------------------------------------------------------------------
module mem_ctrl #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic          cpu_byte,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_err,
    output logic          busy,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic [1:0]    ram_be,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        WR,
        RMW_RD,
        RMW_WAIT,
        RMW_WR
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          byte_q, byte_d;
    logic [7:0]    wbyte_q, wbyte_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    // Doubles as the RMW merge buffer; holding it in a register also keeps
    // ram_wdata stable while idle.
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;

    logic [7:0]    rd_lane;

    assign rd_lane = addr_q[0] ? ram_rdata[15:8] : ram_rdata[7:0];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        byte_d      = byte_q;
        wbyte_d     = wbyte_q;
        rdata_d     = rdata_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        ram_wdata_d = ram_wdata_q;

        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (!cpu_byte && cpu_addr[0]) begin
                        // Misaligned word access: answer at once and leave
                        // the latched address (and so ram_addr) untouched.
                        ack_d = 1'b1;
                        err_d = 1'b1;
                    end else begin
                        addr_d  = cpu_addr;
                        byte_d  = cpu_byte;
                        wbyte_d = cpu_wdata[7:0];
                        if (!cpu_we) begin
                            state_d = RD;
                        end else if (!cpu_byte) begin
                            state_d     = WR;
                            ram_wdata_d = cpu_wdata;
                        end else begin
                            state_d = RMW_RD;
                        end
                    end
                end
            end
            RD: state_d = RD_WAIT;
            RD_WAIT: begin
                rdata_d = byte_q ? {{(DW-8){1'b0}}, rd_lane} : ram_rdata;
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            WR: begin
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            RMW_RD: state_d = RMW_WAIT;
            RMW_WAIT: begin
                // Replace only the addressed lane, keep the other as read.
                ram_wdata_d = addr_q[0] ? {wbyte_q, ram_rdata[7:0]}
                                        : {ram_rdata[15:8], wbyte_q};
                state_d     = RMW_WR;
            end
            RMW_WR: begin
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            byte_q      <= 1'b0;
            wbyte_q     <= '0;
            rdata_q     <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            byte_q      <= byte_d;
            wbyte_q     <= wbyte_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_ack   = ack_q;
    assign cpu_err   = err_q;
    assign busy      = (state_q != IDLE);
    assign ram_addr  = {1'b0, addr_q[AW-1:1]};
    assign ram_wdata = ram_wdata_q;
    assign ram_be    = 2'b11;
    // Decoded straight from the state register, so an asynchronous reset
    // kills a pending write in the same instant.
    assign ram_we    = (state_q == WR) || (state_q == RMW_WR);

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
// Table of CPU accesses with hand-derived expected results, driven through
// mem_ctrl against a behavioural registered-read RAM. Expected ack results go
// into a scoreboard queue when a request is driven and are popped when cpu_ack
// is seen. Hand-written sequences cover back-to-back issue, requests while
// busy and reset in the middle of a byte store.
//
// Latency is counted in clock edges from the accept edge to the edge that
// raises cpu_ack. A misaligned word access is answered by the accept edge
// itself, so its ack appears in the cycle right after acceptance and it counts
// as 0 here.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, cpu_byte;
    logic [15:0] cpu_addr, cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ack, cpu_err, busy;
    logic [15:0] ram_addr, ram_wdata;
    logic [1:0]  ram_be;
    logic        ram_we;
    logic [15:0] ram_rdata;

    mem_ctrl #(.AW(16), .DW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_byte  (cpu_byte),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .cpu_err   (cpu_err),
        .busy      (busy),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_be    (ram_be),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Registered-read RAM; only the low 8 word-address bits are decoded.
    logic [15:0] mem [0:255] = '{default: 16'h0000};
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
        ram_rdata <= mem[ram_addr[7:0]];
    end

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic        we;
        logic        bt;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wes;
        logic [15:0] exp_waddr;
        logic [15:0] exp_wdata;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] exp_rdata;
        logic        exp_err;
        logic        chk_rdata;
        int          exp_lat;
        int          c0;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[15];

    int          checks = 0;
    int          errors = 0;
    int          we_cnt = 0;
    int          be_bad = 0;
    logic [15:0] last_waddr = '0;
    logic [15:0] last_wdata = '0;

    function automatic vec_t mk(logic we, logic bt, logic [15:0] addr,
                                logic [15:0] wdata, logic [15:0] exp_rdata,
                                logic exp_err, int exp_lat, int exp_wes,
                                logic [15:0] exp_waddr, logic [15:0] exp_wdata);
        vec_t v;
        v.we = we; v.bt = bt; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        v.exp_wes = exp_wes; v.exp_waddr = exp_waddr; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: observe outputs at the falling edge, return 1 time unit
    // after the next rising edge.
    task automatic step();
        sb_t e;
        @(negedge clk);
        if (ram_be !== 2'b11) be_bad++;
        if (ram_we) begin
            we_cnt++;
            last_waddr = ram_addr;
            last_wdata = ram_wdata;
        end
        if (cpu_ack) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ack", {31'd0, cpu_ack}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                $display("txn addr=%h err=%0b rdata=%h lat=%0d",
                         e.addr, cpu_err, cpu_rdata, cycle - e.c0);
                check("ack_err", {31'd0, cpu_err}, {31'd0, e.exp_err});
                check("ack_latency", cycle - e.c0, e.exp_lat);
                if (e.chk_rdata) check("ack_rdata", cpu_rdata, e.exp_rdata);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(logic [15:0] addr, logic [15:0] exp_rdata, logic exp_err,
                        logic chk_rdata, int exp_lat);
        sb_t e;
        e.addr = addr; e.exp_rdata = exp_rdata; e.exp_err = exp_err;
        e.chk_rdata = chk_rdata; e.exp_lat = exp_lat;
        e.c0 = cycle + 1;   // the upcoming rising edge accepts the request
        sb_q.push_back(e);
    endtask

    task automatic drive(logic we, logic bt, logic [15:0] addr, logic [15:0] wdata);
        cpu_req = 1'b1; cpu_we = we; cpu_byte = bt;
        cpu_addr = addr; cpu_wdata = wdata;
        step();
        cpu_req = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
        check("ack_timeout_pending", sb_q.size(), 0);
        sb_q.delete();
        step();   // one extra cycle so a doubled ack is caught
    endtask

    task automatic run_vec(vec_t v);
        we_cnt = 0;
        push(v.addr, v.exp_rdata, v.exp_err, !v.we || v.exp_err, v.exp_lat);
        drive(v.we, v.bt, v.addr, v.wdata);
        wait_idle();
        check("ram_we_pulses", we_cnt, v.exp_wes);
        if (v.exp_wes != 0) begin
            check("ram_waddr", last_waddr, v.exp_waddr);
            check("ram_wdata", last_wdata, v.exp_wdata);
        end
    endtask

    initial begin
        //              we bt addr      wdata     rdata     err lat wes waddr     wdata
        vecs[0]  = mk(1, 0, 16'h0004, 16'hBEEF, 16'h0000, 0, 1, 1, 16'h0002, 16'hBEEF);
        vecs[1]  = mk(0, 0, 16'h0004, 16'h0000, 16'hBEEF, 0, 2, 0, 16'h0000, 16'h0000);
        vecs[2]  = mk(1, 0, 16'h0010, 16'h1234, 16'h0000, 0, 1, 1, 16'h0008, 16'h1234);
        vecs[3]  = mk(1, 1, 16'h0011, 16'h00AB, 16'h0000, 0, 3, 1, 16'h0008, 16'hAB34);
        vecs[4]  = mk(0, 0, 16'h0010, 16'h0000, 16'hAB34, 0, 2, 0, 16'h0000, 16'h0000);
        vecs[5]  = mk(0, 1, 16'h0010, 16'h0000, 16'h0034, 0, 2, 0, 16'h0000, 16'h0000);
        vecs[6]  = mk(0, 1, 16'h0011, 16'h0000, 16'h00AB, 0, 2, 0, 16'h0000, 16'h0000);
        vecs[7]  = mk(0, 0, 16'h0003, 16'h0000, 16'h00AB, 1, 0, 0, 16'h0000, 16'h0000);
        vecs[8]  = mk(1, 0, 16'h0003, 16'h9999, 16'h00AB, 1, 0, 0, 16'h0000, 16'h0000);
        vecs[9]  = mk(1, 1, 16'h0010, 16'h77CD, 16'h0000, 0, 3, 1, 16'h0008, 16'hABCD);
        vecs[10] = mk(0, 0, 16'h0010, 16'h0000, 16'hABCD, 0, 2, 0, 16'h0000, 16'h0000);
        vecs[11] = mk(1, 0, 16'hFFFE, 16'hC3A5, 16'h0000, 0, 1, 1, 16'h7FFF, 16'hC3A5);
        vecs[12] = mk(1, 1, 16'hFFFF, 16'h1166, 16'h0000, 0, 3, 1, 16'h7FFF, 16'h66A5);
        vecs[13] = mk(0, 0, 16'hFFFE, 16'h0000, 16'h66A5, 0, 2, 0, 16'h0000, 16'h0000);
        vecs[14] = mk(0, 1, 16'hFFFF, 16'h0000, 16'h0066, 0, 2, 0, 16'h0000, 16'h0000);

        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_byte = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        repeat (3) step();

        check("rst_cpu_ack",   {31'd0, cpu_ack}, 32'd0);
        check("rst_cpu_err",   {31'd0, cpu_err}, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_busy",      {31'd0, busy}, 32'd0);
        check("rst_ram_we",    {31'd0, ram_we}, 32'd0);
        check("rst_ram_addr",  ram_addr, 32'h0);
        check("rst_ram_wdata", ram_wdata, 32'h0);
        check("rst_ram_be",    ram_be, 32'h3);

        // Release away from an edge; the first vector must be accepted at the
        // very next rising edge (its latency check depends on that).
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // Load issued during the ack cycle of a word store.
        we_cnt = 0;
        push(16'h0040, 16'h0000, 1'b0, 1'b0, 1);
        drive(1'b1, 1'b0, 16'h0040, 16'h5555);
        step();
        check("b2b_ack_now",  {31'd0, cpu_ack}, 32'd1);
        check("b2b_idle_now", {31'd0, busy}, 32'd0);
        push(16'h0040, 16'h5555, 1'b0, 1'b1, 2);
        drive(1'b0, 1'b0, 16'h0040, 16'h0000);
        wait_idle();
        check("b2b_ram_we_pulses", we_cnt, 1);

        // Requests pulsed while a byte store is busy are dropped.
        we_cnt = 0;
        push(16'h0041, 16'h0000, 1'b0, 1'b0, 3);
        drive(1'b1, 1'b1, 16'h0041, 16'h00EE);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 16'h0003;
        step();
        cpu_req = 1'b0;
        step();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_byte = 1'b0; cpu_addr = 16'h0040;
        cpu_wdata = 16'h0BAD;
        step();
        cpu_req = 1'b0;
        wait_idle();
        check("busy_req_ram_we_pulses", we_cnt, 1);
        run_vec(mk(0, 0, 16'h0040, 16'h0000, 16'hEE55, 0, 2, 0, 16'h0000, 16'h0000));

        // Reset while a byte store to 0x0020 sits in RMW_WAIT.
        run_vec(mk(1, 0, 16'h0020, 16'h5A5A, 16'h0000, 0, 1, 1, 16'h0010, 16'h5A5A));
        we_cnt = 0;
        drive(1'b1, 1'b1, 16'h0020, 16'h00FF);
        step();
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy_after", {31'd0, busy}, 32'd0);
        check("abort_no_ack",     {31'd0, cpu_ack}, 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        check("abort_ram_we_pulses", we_cnt, 0);
        run_vec(mk(0, 0, 16'h0020, 16'h0000, 16'h5A5A, 0, 2, 0, 16'h0000, 16'h0000));

        check("ram_be_never_changed", be_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
